// File: rtl/up_dn_counter_param_if.sv
// Control/status bundle for up_dn_counter_param: the master drives the controls
// (clr, load, load_val, en, up_dn) and the slave (the counter) drives out, tc, bound_flag.
interface up_dn_counter_param_if #(
  parameter int WIDTH = 5
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             bound_flag;

  modport master (output clr, load, load_val, en, up_dn, input out, tc, bound_flag);
  modport slave  (input clr, load, load_val, en, up_dn, output out, tc, bound_flag);
endinterface

// File: rtl/up_dn_counter_param.sv
// Parametrised up/down modulo counter with wrap or saturate, registered tc pulse and
// sticky boundary flag. Optional prescaler enabled by macro COUNTER_PRESCALER_EN.
module up_dn_counter_param #(
  parameter int              WIDTH     = 5,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 0,
  parameter int              SATURATE  = 0,
  parameter int              PRESCALE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  up_dn_counter_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("up_dn_counter_param: WIDTH must be 1..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("up_dn_counter_param: MAX_VAL out of range");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("up_dn_counter_param: RESET_VAL exceeds MAX_VAL");
  end
  if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
    $error("up_dn_counter_param: SATURATE must be 0 or 1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("up_dn_counter_param: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             flag_q, flag_d;
  logic             step;

`ifdef COUNTER_PRESCALER_EN
  localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    flag_d = flag_q;
    step   = 1'b0;
`ifdef COUNTER_PRESCALER_EN
    pre_d  = pre_q;
`endif
    if (bus.clr) begin
      cnt_d  = RST_W;
      flag_d = 1'b0;
`ifdef COUNTER_PRESCALER_EN
      pre_d  = '0;
`endif
    end else if (bus.load) begin
      cnt_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
`ifdef COUNTER_PRESCALER_EN
      pre_d = '0;
`endif
    end else if (bus.en) begin
`ifdef COUNTER_PRESCALER_EN
      // Only the last enabled cycle of each prescale period advances the count.
      if (pre_q == PRE_LAST) begin
        step  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
`else
      step = 1'b1;
`endif
    end

    if (step) begin
      if (bus.up_dn) begin
        if (cnt_q == MAX_W) begin
          cnt_d  = (SATURATE != 0) ? MAX_W : '0;
          tc_d   = 1'b1;
          flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = (SATURATE != 0) ? '0 : MAX_W;
          tc_d   = 1'b1;
          flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= RST_W;
      tc_q   <= 1'b0;
      flag_q <= 1'b0;
`ifdef COUNTER_PRESCALER_EN
      pre_q  <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      flag_q <= flag_d;
`ifdef COUNTER_PRESCALER_EN
      pre_q  <= pre_d;
`endif
    end
  end

  assign bus.out        = cnt_q;
  assign bus.tc         = tc_q;
  assign bus.bound_flag = flag_q;

endmodule

// File: tb/tb_up_dn_counter_param.sv
// Directed bench for up_dn_counter_param: several parameterisations share clk/reset,
// each scenario task drives one instance and checks hand-computed values.
module tb_up_dn_counter_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  up_dn_counter_param_if #(.WIDTH(5)) i0 ();
  up_dn_counter_param_if #(.WIDTH(5)) i1 ();
  up_dn_counter_param_if #(.WIDTH(5)) i2 ();
  up_dn_counter_param_if #(.WIDTH(5)) i3 ();
  up_dn_counter_param_if #(.WIDTH(5)) i4 ();

  up_dn_counter_param #(.WIDTH(5), .PRESCALE(1)) u0 (.clk(clk), .reset(reset), .bus(i0.slave));
  up_dn_counter_param #(.WIDTH(5), .MAX_VAL(9), .PRESCALE(1)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
  up_dn_counter_param #(.WIDTH(5), .SATURATE(1), .PRESCALE(1)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));
  up_dn_counter_param #(.WIDTH(5), .MAX_VAL(20), .PRESCALE(1)) u3 (.clk(clk), .reset(reset), .bus(i3.slave));
  up_dn_counter_param #(.WIDTH(5), .PRESCALE(4)) u4 (.clk(clk), .reset(reset), .bus(i4.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle_all();
    i0.clr = 0; i0.load = 0; i0.load_val = '0; i0.en = 0; i0.up_dn = 1;
    i1.clr = 0; i1.load = 0; i1.load_val = '0; i1.en = 0; i1.up_dn = 1;
    i2.clr = 0; i2.load = 0; i2.load_val = '0; i2.en = 0; i2.up_dn = 1;
    i3.clr = 0; i3.load = 0; i3.load_val = '0; i3.en = 0; i3.up_dn = 1;
    i4.clr = 0; i4.load = 0; i4.load_val = '0; i4.en = 0; i4.up_dn = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if (i0.out !== 5'd0 || i0.tc !== 1'b0 || i0.bound_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_u0 got out=%0d tc=%b flag=%b want 0 0 0", i0.out, i0.tc, i0.bound_flag);
    end
    total++;
    if (i1.out !== 5'd0 || i3.out !== 5'd0 || i2.tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_others got u1=%0d u3=%0d u2tc=%b want 0 0 0", i1.out, i3.out, i2.tc);
    end
    do_reset();
  endtask

  task automatic test_up_wrap();
    do_reset();
    i0.up_dn = 1; i0.en = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      total++;
      if (i0.out !== 5'(i % 32) || i0.tc !== (i == 32) || i0.bound_flag !== (i >= 32)) begin
        bad++;
        $display("FAIL up_wrap step %0d got out=%0d tc=%b flag=%b want %0d %b %b",
                 i, i0.out, i0.tc, i0.bound_flag, i % 32, (i == 32), (i >= 32));
      end
    end
    i0.en = 0;
    tick();
    tick();
    total++;
    if (i0.out !== 5'd8 || i0.tc !== 1'b0) begin
      bad++;
      $display("FAIL hold got out=%0d tc=%b want 8 0", i0.out, i0.tc);
    end
  endtask

  task automatic test_down_mod9();
    do_reset();
    i1.up_dn = 0; i1.en = 1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      total++;
      if (i1.out !== 5'((10 - i % 10) % 10) || i1.tc !== (i == 1 || i == 11)) begin
        bad++;
        $display("FAIL down_mod9 step %0d got out=%0d tc=%b want %0d %b",
                 i, i1.out, i1.tc, (10 - i % 10) % 10, (i == 1 || i == 11));
      end
    end
    i1.en = 0;
  endtask

  task automatic test_saturate();
    logic [4:0] exp_out [0:6];
    logic       exp_tc  [0:6];
    exp_out = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd30, 5'd29};
    exp_tc  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    i2.load = 1; i2.load_val = 5'd30;
    tick();
    i2.load = 0;
    total++;
    if (i2.out !== 5'd30 || i2.tc !== 1'b0) begin
      bad++;
      $display("FAIL sat_load got out=%0d tc=%b want 30 0", i2.out, i2.tc);
    end
    i2.en = 1; i2.up_dn = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) i2.up_dn = 0;
      tick();
      total++;
      if (i2.out !== exp_out[i] || i2.tc !== exp_tc[i]) begin
        bad++;
        $display("FAIL saturate step %0d got out=%0d tc=%b want %0d %b",
                 i, i2.out, i2.tc, exp_out[i], exp_tc[i]);
      end
    end
    i2.en = 0;
    total++;
    if (i2.bound_flag !== 1'b1) begin
      bad++;
      $display("FAIL sat_flag got %b want 1", i2.bound_flag);
    end
  endtask

  task automatic test_clamp_clr();
    do_reset();
    i3.load = 1; i3.load_val = 5'd27; i3.en = 1; i3.up_dn = 1;
    tick();
    i3.load = 0;
    total++;
    if (i3.out !== 5'd20 || i3.tc !== 1'b0 || i3.bound_flag !== 1'b0) begin
      bad++;
      $display("FAIL clamp got out=%0d tc=%b flag=%b want 20 0 0", i3.out, i3.tc, i3.bound_flag);
    end
    tick();
    total++;
    if (i3.out !== 5'd0 || i3.tc !== 1'b1 || i3.bound_flag !== 1'b1) begin
      bad++;
      $display("FAIL wrap20 got out=%0d tc=%b flag=%b want 0 1 1", i3.out, i3.tc, i3.bound_flag);
    end
    tick();
    i3.clr = 1; i3.load = 1; i3.load_val = 5'd7;
    tick();
    i3.clr = 0; i3.load = 0; i3.en = 0;
    total++;
    if (i3.out !== 5'd0 || i3.tc !== 1'b0 || i3.bound_flag !== 1'b0) begin
      bad++;
      $display("FAIL clr got out=%0d tc=%b flag=%b want 0 0 0", i3.out, i3.tc, i3.bound_flag);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i0.up_dn = 1; i0.en = 1;
    repeat (13) tick();
    total++;
    if (i0.out !== 5'd13) begin
      bad++;
      $display("FAIL pre_reset got out=%0d want 13", i0.out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (i0.out !== 5'd0 || i0.tc !== 1'b0 || i0.bound_flag !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got out=%0d tc=%b flag=%b want 0 0 0", i0.out, i0.tc, i0.bound_flag);
    end
    #2 reset = 1'b1;
    tick();
    tick();
    i0.en = 0;
    total++;
    if (i0.out !== 5'd2) begin
      bad++;
      $display("FAIL resume got out=%0d want 2", i0.out);
    end
  endtask

`ifdef COUNTER_PRESCALER_EN
  task automatic test_prescale();
    do_reset();
    i4.up_dn = 1; i4.en = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++;
      if (i4.out !== 5'(i / 4)) begin
        bad++;
        $display("FAIL prescale cycle %0d got out=%0d want %0d", i, i4.out, i / 4);
      end
    end
    repeat (2) tick();
    i4.en = 0;
    repeat (3) tick();
    i4.en = 1;
    tick();
    total++;
    if (i4.out !== 5'd3) begin
      bad++;
      $display("FAIL prescale_hold got out=%0d want 3", i4.out);
    end
    tick();
    i4.en = 0;
    total++;
    if (i4.out !== 5'd4 || i4.tc !== 1'b0) begin
      bad++;
      $display("FAIL prescale_phase got out=%0d tc=%b want 4 0", i4.out, i4.tc);
    end
  endtask
`endif

  initial begin
    idle_all();
    test_reset();
    test_up_wrap();
    test_down_mod9();
    test_saturate();
    test_clamp_clr();
    test_async_reset();
`ifdef COUNTER_PRESCALER_EN
    test_prescale();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
